qdivs: RTL
==========

Name: qdivs

Overview:
- Sequential signed-magnitude fixed-point divider; the inverse operation of the team's sequential Q-format multiplier.
- Uses the same Q/N number format and the same start/complete handshake, so datapath FSMs can use either unit interchangeably.
- Computes dividend / divisor as a restoring shift-subtract, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath.

Parameters:
- Q, 8, number of fractional bits.
- N, 16, total word width: 1 sign bit plus N-1 magnitude bits.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_dividend  input  N  signed-magnitude Q-format dividend.
- i_divisor  input  N  signed-magnitude Q-format divisor.
- i_start  input  1  start request; accepted only while o_complete=1.
- o_quotient_out  output  N  bit N-1 is the sign, bits N-2:0 are the magnitude.
- o_complete  output  1  1 = idle/result valid; 0 = busy.
- o_overflow  output  1  quotient magnitude not representable, or divide by zero.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_complete=1, o_quotient_out=0, o_overflow=0, FSM to IDLE.
  - Reset has priority over everything and aborts any division in progress; no result is produced.
- Derived constants:
  - ITER = N-1+Q (23 by default).
  - Counter width = clog2(ITER+1).
- FSM states: IDLE, RUN, DONE.
- IDLE, on i_start=1:
  - Latch magnitudes A=i_dividend[N-2:0] and B=i_divisor[N-2:0], and sign S=i_dividend[N-1]^i_divisor[N-1].
  - Clear o_overflow and drive o_complete=0 at this edge.
  - Operand changes after the accept edge are ignored.
- Divide by zero (B==0 at accept):
  - Go to DONE with quotient magnitude forced to all ones and overflow=1. No RUN cycles.
- RUN:
  - Working dividend D = A<<Q (ITER bits); remainder R is N bits, initialised to 0; count k runs ITER-1 down to 0.
  - Each cycle: T = {R[N-2:0], D[k]}. If T>=B then R=T-B and qbit=1, else R=T and qbit=0.
  - Shift qbit into the ITER-bit quotient register QF, MSB first.
  - After the k=0 cycle go to DONE.
- DONE (one cycle, internal):
  - o_quotient_out <= {S, QF[N-2:0]}.
  - o_overflow <= (QF[ITER-1:N-1] != 0).
  - o_complete <= 1; FSM to IDLE.
  - On divide by zero the output is {S, all ones}.
- Latency:
  - o_complete is low for exactly ITER+1 cycles (24 by default) after the accept edge.
  - Divide by zero: o_complete is low for exactly 1 cycle.
- Output stability:
  - o_quotient_out and o_overflow hold their previous values throughout the busy period.
  - They change only on the DONE edge, or on the accept edge (o_overflow clears).
- Start handling:
  - i_start while busy is ignored, with no queuing.
  - i_start held high continuously gives back-to-back divisions: a new accept on the first IDLE cycle after DONE.
- Sign rules:
  - Sign is always the XOR of the input signs, including when the magnitude is 0 (a -0 result is permitted).
  - A zero dividend with a nonzero divisor runs the full latency and gives magnitude 0.
- Truncation: the quotient is truncated toward zero, with no rounding.

Decomposition:
- Shared package qfix_pkg holds:
  - defaults Q_DEF=8 and N_DEF=16;
  - function f_iter(N,Q)=N-1+Q;
  - FSM state encodings IDLE/RUN/DONE;
  - localparam MAG_ALL_ONES.
- One sub-module, qdiv_step: combinational compare-subtract of one restoring step.
  - Inputs: R, next dividend bit, B.
  - Outputs: next R, qbit.
  - Parameterised by N, and reusable by a future pipelined divider.

Test Plan (Q=8, N=16):
- 0x0300 / 0x0200 (3.0/2.0) -> 0x0180, overflow=0; o_complete low exactly 24 cycles.
- 0x8300 / 0x0200 (-3.0/2.0) -> 0x8180; 0x8300 / 0x8200 -> 0x0180, overflow=0.
- 0x7F00 / 0x0080 (127/0.5) -> overflow=1, o_quotient_out=0x7E00 (truncated bits of 0xFE00).
- 0x8100 / 0x0000 -> o_quotient_out=0xFFFF, overflow=1; o_complete low exactly 1 cycle.
- 0x0001 / 0x0300 -> 0x0000, overflow=0; then i_start pulsed mid-run with new operands -> ignored, first result unchanged.
- Drive i_rst_n=0 at cycle 10 of a run -> next edge o_complete=1, o_quotient_out=0, o_overflow=0; then a fresh 0x0100/0x0100 -> 0x0100.

Source files
------------

// File: rtl/qfix_pkg.sv
// Shared definitions for the Q-format arithmetic units (multiplier / divider).
package qfix_pkg;

    localparam int Q_DEF = 8;
    localparam int N_DEF = 16;

    // Wide all-ones constant; units slice off the magnitude width they need.
    localparam logic [63:0] MAG_ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Quotient bits produced by the divider: N-1 integer+fraction magnitude bits plus Q extra.
    function automatic int f_iter(input int n, input int q);
        return n - 1 + q;
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module qdiv_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_r,
    input  logic         i_dbit,
    input  logic [N-2:0] i_b,
    output logic [N-1:0] o_r,
    output logic         o_qbit
);

    logic [N-1:0] w_t;
    logic [N-1:0] w_b;

    assign w_t = {i_r[N-2:0], i_dbit};
    assign w_b = {1'b0, i_b};

    // Keep the difference when the trial remainder covers the divisor.
    always_comb begin
        o_qbit = 1'b0;
        o_r    = w_t;
        if (w_t >= w_b) begin
            o_qbit = 1'b1;
            o_r    = w_t - w_b;
        end
    end

endmodule

// File: rtl/qdivs.sv
// Sequential signed-magnitude Q-format divider, one quotient bit per clock.
module qdivs
    import qfix_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int ITER = f_iter(N, Q);
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] K_LAST = CW'(ITER - 1);

    state_t r_state;
    state_t w_next;

    logic [ITER-1:0] r_d;     // dividend magnitude pre-shifted by Q
    logic [ITER-1:0] r_qf;    // full-width quotient, MSB shifted in first
    logic [N-2:0]    r_b;
    logic [N-1:0]    r_r;
    logic            r_s;
    logic            r_dz;
    logic [CW-1:0]   r_k;
    logic [N-1:0]    r_quot;
    logic            r_ovf;
    logic            r_complete;

    logic [N-1:0]    w_r_nxt;
    logic            w_qbit;
    logic            w_div_zero;

    assign w_div_zero = (i_divisor[N-2:0] == '0);

    qdiv_step #(.N(N)) u_step (
        .i_r    (r_r),
        .i_dbit (r_d[r_k]),
        .i_b    (r_b),
        .o_r    (w_r_nxt),
        .o_qbit (w_qbit)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: zero divisor skips the iteration entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = w_div_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_k == '0) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate, publish result in DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_d        <= '0;
            r_qf       <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_s        <= 1'b0;
            r_dz       <= 1'b0;
            r_k        <= '0;
            r_quot     <= '0;
            r_ovf      <= 1'b0;
            r_complete <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_d        <= ITER'(i_dividend[N-2:0]) << Q;
                        r_b        <= i_divisor[N-2:0];
                        r_s        <= i_dividend[N-1] ^ i_divisor[N-1];
                        r_dz       <= w_div_zero;
                        r_r        <= '0;
                        r_qf       <= '0;
                        r_k        <= K_LAST;
                        r_ovf      <= 1'b0;
                        r_complete <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_r  <= w_r_nxt;
                    r_qf <= {r_qf[ITER-2:0], w_qbit};
                    r_k  <= r_k - 1'b1;
                end
                ST_DONE: begin
                    if (r_dz) begin
                        r_quot <= {r_s, MAG_ALL_ONES[N-2:0]};
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quot <= {r_s, r_qf[N-2:0]};
                        r_ovf  <= (r_qf[ITER-1:N-1] != '0);
                    end
                    r_complete <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_quotient_out = r_quot;
    assign o_overflow     = r_ovf;
    assign o_complete     = r_complete;

endmodule
